mdu_sequencer: RTL

//  Multi-cycle controller and datapath for the RV64M ops the decoder emits on ctl.mduop:
//  MDU_MUL, MDU_MULW, MDU_DIV, MDU_REM, MDU_REMU.

---
 rtl/mdu_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// RV64M multiply/divide sequencer: one-bit-per-cycle shift-add multiply and
// restoring divide behind a valid/ready handshake, with flush and sign fixup.

package mdu_pkg;
  typedef enum logic [2:0] {
    MDU_MUL  = 3'd0,
    MDU_MULW = 3'd1,
    MDU_DIV  = 3'd2,
    MDU_REM  = 3'd3,
    MDU_REMU = 3'd4
  } mdu_op_t;
endpackage

module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  mdu_op_t          mduop,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  mdu_op_t          op_q, op_n;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;   // product accumulator / partial remainder
  logic [WIDTH-1:0] opa_q;   // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opb_q;   // multiplicand / divisor
  logic             neg_quo_q, neg_rem_q;

  logic             accept;
  logic             is_signed_div, is_any_div, b_zero, ovf, special;
  logic [WIDTH-1:0] special_res, abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, diff;

  assign in_ready = (state_q == S_IDLE) & ~reset;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE) & ~flush;
  assign accept   = in_valid & in_ready & ~flush;

  // Undefined encodings fall back to MUL.
  always_comb begin
    op_n = MDU_MUL;
    case (mduop)
      MDU_MULW, MDU_DIV, MDU_REM, MDU_REMU: op_n = mduop;
      default:                              op_n = MDU_MUL;
    endcase
  end

  // Divide-by-zero and signed overflow resolve in the accept cycle.
  always_comb begin
    is_signed_div = (op_n == MDU_DIV) | (op_n == MDU_REM);
    is_any_div    = is_signed_div | (op_n == MDU_REMU);
    b_zero        = (src_b == '0);
    ovf           = (src_a == MIN_NEG) & (src_b == '1);
    special       = (is_any_div & b_zero) | (is_signed_div & ovf);
    special_res   = src_a;
    if (op_n == MDU_DIV && b_zero)     special_res = '1;
    else if (op_n == MDU_REM && !b_zero) special_res = '0;
    abs_a = src_a[WIDTH-1] ? WIDTH'(-src_a) : src_a;
    abs_b = src_b[WIDTH-1] ? WIDTH'(-src_b) : src_b;
  end

  always_comb begin
    rem_sh = {acc_q, opa_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opb_q};
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_ITER;
      S_ITER: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath; a flush freezes everything, including result.
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= MDU_MUL;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (special) begin
              result <= special_res;
            end else begin
              op_q      <= op_n;
              cnt_q     <= (op_n == MDU_MULW) ? CNT_W'(HALF) : CNT_W'(WIDTH);
              acc_q     <= '0;
              neg_quo_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
              neg_rem_q <= src_a[WIDTH-1];
              if (is_signed_div) begin
                opa_q <= abs_a;
                opb_q <= abs_b;
              end else if (is_any_div) begin
                opa_q <= src_a;
                opb_q <= src_b;
              end else begin
                opa_q <= src_b;
                opb_q <= src_a;
              end
            end
          end
        end
        S_ITER: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (op_q == MDU_MUL || op_q == MDU_MULW) begin
            if (opa_q[0]) acc_q <= acc_q + opb_q;
            opb_q <= opb_q << 1;
            opa_q <= opa_q >> 1;
          end else if (!diff[WIDTH]) begin
            acc_q <= diff[WIDTH-1:0];
            opa_q <= {opa_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_q <= rem_sh[WIDTH-1:0];
            opa_q <= {opa_q[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          case (op_q)
            MDU_MULW: result <= {{HALF{acc_q[HALF-1]}}, acc_q[HALF-1:0]};
            MDU_DIV:  result <= neg_quo_q ? WIDTH'(-opa_q) : opa_q;
            MDU_REM:  result <= neg_rem_q ? WIDTH'(-acc_q) : acc_q;
            MDU_REMU: result <= acc_q;
            default:  result <= acc_q;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
